// File: rtl/core_status_regs_pkg.sv
// rtl/core_status_regs_pkg.sv - shared constants, FSM state type and helpers for core_status_regs
//
// Purpose: register map addresses, default bus widths, the command FSM state
// enum and a saturating increment used by the loss counter.
package core_status_regs_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 32;

  localparam int unsigned REG_ID       = 32'h0;
  localparam int unsigned REG_SCRATCH  = 32'h1;
  localparam int unsigned REG_STATUS   = 32'h2;
  localparam int unsigned REG_STICKY   = 32'h3;
  localparam int unsigned REG_LOSS_CNT = 32'h4;
  localparam int unsigned REG_UPTIME   = 32'h5;

  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXEC      = 2'd1,
    ST_ACK       = 2'd2,
    ST_WAIT_DROP = 2'd3
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/core_status_regs_if.sv
// rtl/core_status_regs_if.sv - command request/ack bundle for core_status_regs
//
// Purpose: groups the command handshake signals.
// master: drives cmd_valid/cmd_rd_wr_n/cmd_addr/cmd_wdata, receives cmd_ack/cmd_rdata.
// slave : the register block side.
interface core_status_regs_if #(
  parameter int ADDR_BITS = core_status_regs_pkg::DEFAULT_ADDR_BITS,
  parameter int DATA_BITS = core_status_regs_pkg::DEFAULT_DATA_BITS
);
  logic                 cmd_valid;
  logic                 cmd_rd_wr_n;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [DATA_BITS-1:0] cmd_wdata;
  logic                 cmd_ack;
  logic [DATA_BITS-1:0] cmd_rdata;

  modport master (
    output cmd_valid, cmd_rd_wr_n, cmd_addr, cmd_wdata,
    input  cmd_ack, cmd_rdata
  );

  modport slave (
    input  cmd_valid, cmd_rd_wr_n, cmd_addr, cmd_wdata,
    output cmd_ack, cmd_rdata
  );
endinterface

// File: rtl/core_status_regs_sync_2ff.sv
// rtl/core_status_regs_sync_2ff.sv - two-flop synchronizer for one asynchronous bit
//
// Ports: clk (destination clock), rst (async active-high, clears both flops),
//        d (asynchronous input), q (synchronized output).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/core_status_regs.sv
// rtl/core_status_regs.sv - status/control register block with held-valid command handshake
//
// Purpose: six-register map (ID, SCRATCH, STATUS, STICKY, LOSS_CNT, UPTIME)
// accessed through a valid/ack command port; tracks PLL lock and deskew loss.
// Ports: i_sys_clk/i_ext_arst clock and async reset; i_cmd_* command request
// (valid held until ack); o_cmd_ack one-cycle completion, o_cmd_rdata read
// data; i_pll_locked/i_deskew_done asynchronous status inputs.
module core_status_regs
  import core_status_regs_pkg::*;
#(
  parameter logic [31:0] ID_VALUE  = 32'h0000_0000,
  parameter int          ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int          DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 i_sys_clk,
  input  logic                 i_ext_arst,
  input  logic                 i_cmd_valid,
  input  logic                 i_cmd_rd_wr_n,
  input  logic [ADDR_BITS-1:0] i_cmd_addr,
  input  logic [DATA_BITS-1:0] i_cmd_wdata,
  output logic                 o_cmd_ack,
  output logic [DATA_BITS-1:0] o_cmd_rdata,
  input  logic                 i_pll_locked,
  input  logic                 i_deskew_done
);
  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 rd_q, rd_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic [DATA_BITS-1:0] scratch_q, scratch_d;
  logic [1:0]           sticky_q, sticky_d;
  logic [15:0]          loss_cnt_q, loss_cnt_d;
  logic [31:0]          uptime_q, uptime_d;
  logic                 lock_prev_q, lock_prev_d;
  logic                 deskew_prev_q, deskew_prev_d;

  logic                 lock_s, deskew_s;
  logic                 lock_fall, deskew_fall;
  logic                 exec, wr_en;
  logic [1:0]           sticky_clr;
  logic [DATA_BITS-1:0] rd_value;

  sync_2ff u_sync_lock   (.clk(i_sys_clk), .rst(i_ext_arst), .d(i_pll_locked),  .q(lock_s));
  sync_2ff u_sync_deskew (.clk(i_sys_clk), .rst(i_ext_arst), .d(i_deskew_done), .q(deskew_s));

  always_ff @(posedge i_sys_clk or posedge i_ext_arst) begin
    if (i_ext_arst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      rd_q          <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      scratch_q     <= '0;
      sticky_q      <= '0;
      loss_cnt_q    <= '0;
      uptime_q      <= '0;
      lock_prev_q   <= 1'b0;
      deskew_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rd_q          <= rd_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      scratch_q     <= scratch_d;
      sticky_q      <= sticky_d;
      loss_cnt_q    <= loss_cnt_d;
      uptime_q      <= uptime_d;
      lock_prev_q   <= lock_prev_d;
      deskew_prev_q <= deskew_prev_d;
    end
  end

  // WAIT_DROP blocks a still-held request from being taken a second time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (i_cmd_valid) state_d = ST_EXEC;
      ST_EXEC:      state_d = ST_ACK;
      ST_ACK:       state_d = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!i_cmd_valid) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ack   = (state_q == ST_ACK);
    o_cmd_rdata = rdata_q;
  end

  always_comb begin
    addr_d  = addr_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (state_q == ST_IDLE && i_cmd_valid) begin
      addr_d  = i_cmd_addr;
      rd_d    = i_cmd_rd_wr_n;
      wdata_d = i_cmd_wdata;
    end
  end

  always_comb begin
    rd_value = DATA_BITS'(UNMAPPED_RDATA);
    case (addr_q)
      ADDR_BITS'(REG_ID):       rd_value = DATA_BITS'(ID_VALUE);
      ADDR_BITS'(REG_SCRATCH):  rd_value = scratch_q;
      ADDR_BITS'(REG_STATUS):   rd_value = DATA_BITS'({deskew_s, lock_s});
      ADDR_BITS'(REG_STICKY):   rd_value = DATA_BITS'(sticky_q);
      ADDR_BITS'(REG_LOSS_CNT): rd_value = DATA_BITS'(loss_cnt_q);
      ADDR_BITS'(REG_UPTIME):   rd_value = DATA_BITS'(uptime_q);
      default:                  rd_value = DATA_BITS'(UNMAPPED_RDATA);
    endcase
  end

  always_comb begin
    exec          = (state_q == ST_EXEC);
    wr_en         = exec && !rd_q;
    lock_fall     = lock_prev_q && !lock_s;
    deskew_fall   = deskew_prev_q && !deskew_s;
    lock_prev_d   = lock_s;
    deskew_prev_d = deskew_s;
    uptime_d      = uptime_q + 32'd1;

    rdata_d = rdata_q;
    if (exec) rdata_d = rd_q ? rd_value : '0;

    scratch_d = scratch_q;
    if (wr_en && addr_q == ADDR_BITS'(REG_SCRATCH)) scratch_d = wdata_q;

    // Events are OR-ed in after the clear so a same-cycle event wins.
    sticky_clr = '0;
    if (wr_en && addr_q == ADDR_BITS'(REG_STICKY)) sticky_clr = wdata_q[1:0];
    sticky_d = (sticky_q & ~sticky_clr) | {deskew_fall, lock_fall};

    // A clear coinciding with a loss event leaves the count at 1.
    loss_cnt_d = loss_cnt_q;
    if (wr_en && addr_q == ADDR_BITS'(REG_LOSS_CNT)) loss_cnt_d = lock_fall ? 16'd1 : 16'd0;
    else if (lock_fall) loss_cnt_d = sat_inc16(loss_cnt_q);
  end

endmodule

// File: tb/tb_core_status_regs.sv
// tb/tb_core_status_regs.sv - directed self-checking bench for core_status_regs
module tb_core_status_regs;
  localparam logic [31:0] ID = 32'hC0DE_0042;

  logic clk;
  logic rst;
  logic pll_locked;
  logic deskew_done;
  int   checks;
  int   errors;

  core_status_regs_if #(.ADDR_BITS(8), .DATA_BITS(32)) cmd_if ();

  core_status_regs #(.ID_VALUE(ID), .ADDR_BITS(8), .DATA_BITS(32)) dut (
    .i_sys_clk     (clk),
    .i_ext_arst    (rst),
    .i_cmd_valid   (cmd_if.cmd_valid),
    .i_cmd_rd_wr_n (cmd_if.cmd_rd_wr_n),
    .i_cmd_addr    (cmd_if.cmd_addr),
    .i_cmd_wdata   (cmd_if.cmd_wdata),
    .o_cmd_ack     (cmd_if.cmd_ack),
    .o_cmd_rdata   (cmd_if.cmd_rdata),
    .i_pll_locked  (pll_locked),
    .i_deskew_done (deskew_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic rd, input logic [7:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat);
    @(negedge clk);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_rd_wr_n = rd;
    cmd_if.cmd_addr    = addr;
    cmd_if.cmd_wdata   = wdata;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (cmd_if.cmd_ack) break;
    end
    rdata = cmd_if.cmd_rdata;
    cmd_if.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic toggle_lock();
    pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          acks;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    pll_locked = 1'b1;
    deskew_done = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_rd_wr_n = 1'b0;
    cmd_if.cmd_addr = '0;
    cmd_if.cmd_wdata = '0;

    repeat (3) @(negedge clk);
    check("reset_ack", {31'd0, cmd_if.cmd_ack}, 32'd0);
    check("reset_rdata", cmd_if.cmd_rdata, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_cmd(1'b1, 8'h02, 32'd0, rd, lat);
    check("status_live", rd, 32'h3);
    check("status_lat", lat, 32'd2);
    do_cmd(1'b0, 8'h01, 32'hA5A5_5A5A, rd, lat);
    check("scratch_wr_lat", lat, 32'd2);
    do_cmd(1'b1, 8'h01, 32'd0, rd, lat);
    check("scratch_rd", rd, 32'hA5A5_5A5A);
    check("scratch_rd_lat", lat, 32'd2);

    do_cmd(1'b1, 8'h03, 32'd0, rd, lat);
    check("sticky_post_reset", rd, 32'h0);
    do_cmd(1'b1, 8'h04, 32'd0, rd, lat);
    check("loss_post_reset", rd, 32'h0);

    repeat (3) toggle_lock();
    do_cmd(1'b1, 8'h04, 32'd0, rd, lat);
    check("loss_three", rd, 32'd3);
    do_cmd(1'b1, 8'h03, 32'd0, rd, lat);
    check("sticky_lock", rd, 32'h1);
    do_cmd(1'b0, 8'h03, 32'h1, rd, lat);
    do_cmd(1'b1, 8'h03, 32'd0, rd, lat);
    check("sticky_w1c", rd, 32'h0);

    // Lock drops one cycle before the command so the synchronized fall lands in EXEC.
    @(negedge clk);
    pll_locked = 1'b0;
    do_cmd(1'b0, 8'h03, 32'h1, rd, lat);
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);
    do_cmd(1'b1, 8'h03, 32'd0, rd, lat);
    check("sticky_event_wins", rd, 32'h1);
    do_cmd(1'b1, 8'h04, 32'd0, rd, lat);
    check("loss_four", rd, 32'd4);

    @(negedge clk);
    pll_locked = 1'b0;
    do_cmd(1'b0, 8'h04, 32'h0, rd, lat);
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);
    do_cmd(1'b1, 8'h04, 32'd0, rd, lat);
    check("loss_clear_and_inc", rd, 32'd1);
    do_cmd(1'b0, 8'h04, 32'h1234, rd, lat);
    do_cmd(1'b1, 8'h04, 32'd0, rd, lat);
    check("loss_clear", rd, 32'd0);

    @(negedge clk);
    dut.loss_cnt_q = 16'hFFFE;
    repeat (2) toggle_lock();
    do_cmd(1'b1, 8'h04, 32'd0, rd, lat);
    check("loss_saturate", rd, 32'h0000_FFFF);

    do_cmd(1'b0, 8'h03, 32'h3, rd, lat);
    deskew_done = 1'b0;
    repeat (4) @(negedge clk);
    do_cmd(1'b1, 8'h02, 32'd0, rd, lat);
    check("status_deskew_low", rd, 32'h1);
    do_cmd(1'b1, 8'h03, 32'd0, rd, lat);
    check("sticky_deskew", rd, 32'h2);
    deskew_done = 1'b1;
    repeat (4) @(negedge clk);

    do_cmd(1'b1, 8'h7F, 32'd0, rd, lat);
    check("unmapped_rd", rd, 32'hDEAD_BEEF);
    check("unmapped_lat", lat, 32'd2);
    do_cmd(1'b0, 8'h00, 32'hFFFF_FFFF, rd, lat);
    check("id_wr_lat", lat, 32'd2);
    do_cmd(1'b1, 8'h00, 32'd0, rd, lat);
    check("id_unchanged", rd, ID);

    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_rd_wr_n = 1'b1;
    cmd_if.cmd_addr = 8'h01;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_if.cmd_ack) acks++;
    end
    check("held_one_ack", acks, 32'd1);
    cmd_if.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_cmd(1'b1, 8'h01, 32'd0, rd, lat);
    check("reraise_lat", lat, 32'd2);

    // Reset lands while the command is in EXEC; the held request is re-taken afterwards.
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_rd_wr_n = 1'b1;
    cmd_if.cmd_addr = 8'h05;
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (cmd_if.cmd_ack) acks++;
    end
    check("reset_no_ack", acks, 32'd0);
    check("reset_mid_rdata", cmd_if.cmd_rdata, 32'd0);
    rst = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (cmd_if.cmd_ack) break;
    end
    check("reaccept_lat", lat, 32'd2);
    check("reaccept_uptime", cmd_if.cmd_rdata, 32'd1);
    cmd_if.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_cmd(1'b1, 8'h01, 32'd0, rd, lat);
    check("scratch_after_rst", rd, 32'd0);
    do_cmd(1'b1, 8'h03, 32'd0, rd, lat);
    check("sticky_after_rst", rd, 32'd0);
    do_cmd(1'b1, 8'h04, 32'd0, rd, lat);
    check("loss_after_rst", rd, 32'd0);

    @(negedge clk);
    dut.uptime_q = 32'hFFFF_FFFE;
    do_cmd(1'b1, 8'h05, 32'd0, rd, lat);
    check("uptime_wrap", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
